msf_frame_ctrl: RTL and testbench
=================================

Name: msf_frame_ctrl

Overview:
- Sequences the per-second output of the MSF decoder into complete one-minute time-code frames.
- Tracks the second index from the minute marker and captures the A/B bits for each second.
- At the end of each frame, checks the marker and length, then latches BCD date/time registers.
- Sits directly downstream of the decoder; its outputs drive display/readout logic.

Parameters:
- TIMEOUT_CYCLES, 65536: clk_i cycles allowed between bits_valid_i pulses before sync is declared lost. Timeout counter width is $clog2(TIMEOUT_CYCLES+1).

Ports:
- clk_i  input  1  system clock
- rst_i  input  1  reset, asynchronous, active-high
- bits_valid_i  input  1  one-cycle pulse, one per received second
- bits_is_second_00_i  input  1  qualifies bits_valid_i: this second is the minute marker (second 00)
- bits_data_i  input  2  [0]=A bit, [1]=B bit of the current second
- second_o  output  6  current second index 0..59
- year_o  output  8  BCD year 00..99
- month_o  output  5  BCD month
- day_o  output  6  BCD day of month
- dow_o  output  3  day of week 0..6
- hour_o  output  6  BCD hour
- minute_o  output  7  BCD minute
- time_valid_o  output  1  time registers hold a frame that is current and checked
- frame_done_o  output  1  one-cycle pulse: good frame latched
- frame_error_o  output  1  one-cycle pulse: frame rejected or timeout

Behaviour:
- Reset: state=SYNC_WAIT; all outputs 0; shift registers and timeout counter cleared. Reset mid-frame discards all partial data.
- SYNC_WAIT:
  - Ignores bits_valid_i unless bits_is_second_00_i=1.
  - On a marker: second_o<=0, clear capture, go COLLECT.
  - Timeout counter is inactive in this state.
- COLLECT, on bits_valid_i with bits_is_second_00_i=0:
  - If second_o<59: second_o<=second_o+1, then capture.
  - If second_o==59 (61st second, e.g. a leap frame): frame_error_o pulse, time_valid_o<=0, go SYNC_WAIT.
- Capture, keyed on the new second index s:
  - A bits for s=17..59 shift into a 43-bit register.
  - B bits for s=54..57 are stored individually.
  - Other bits are discarded.
- COLLECT, on bits_valid_i with bits_is_second_00_i=1:
  - If second_o!=59 (short frame): error pulse, time_valid_o<=0.
  - Else run the checks. All checks are evaluated combinationally from the stored bits in the same cycle.
  - In every case second_o<=0, capture clears, and the state stays COLLECT (resynced on this marker).
- Checks (all must pass):
  - A bits 52..59 == 8'b01111110.
  - Parity, when MSF_PARITY_CHECK_EN is defined.
- Pass result:
  - year=A17..24, month=A25..29, day=A30..35, dow=A36..38, hour=A39..44, minute=A45..51.
  - Fields are MSB first.
  - Outputs update exactly 1 cycle after the marker pulse, with time_valid_o<=1 and frame_done_o pulsed the same cycle.
- Fail result: frame_error_o pulse, time_valid_o<=0. Time registers keep their last good values.
- Timeout:
  - The counter runs in COLLECT and resets on every bits_valid_i.
  - On reaching TIMEOUT_CYCLES: frame_error_o pulse, time_valid_o<=0, go SYNC_WAIT, second_o<=0.
  - If bits_valid_i arrives in the same cycle as the timeout, the bit wins and the counter resets.
- frame_done_o and frame_error_o are never asserted together.

Optional Feature:
- Macro MSF_PARITY_CHECK_EN.
- Defined: odd parity is also required for each group:
  - year bits plus B54;
  - month+day bits plus B55;
  - dow bits plus B56;
  - hour+minute bits plus B57.
  - Any failing group rejects the frame.
- Undefined: B bits are not stored, and only the length and marker checks apply.

Test Plan:
- Reset, then marker, then 59 bits encoding 23-07-14, dow 5, 12:34, with B54..57=0,0,1,0 and A52..59=01111110, then marker -> one cycle later year_o=8'h23, month_o=5'h07, day_o=6'h14, dow_o=5, hour_o=6'h12, minute_o=7'h34, time_valid_o=1, frame_done_o one pulse.
- Same frame but A53=0 -> frame_error_o pulse, time_valid_o=0, time registers unchanged from the previous good frame.
- With MSF_PARITY_CHECK_EN defined, the good frame with B56 flipped to 0 -> frame_error_o pulse. With the macro undefined, the same frame is accepted.
- Marker arriving after only 58 seconds -> error pulse, second_o=0, next 60-second good frame accepted.
- After a good frame, stop bits_valid_i for TIMEOUT_CYCLES cycles -> frame_error_o pulse, time_valid_o=0, state SYNC_WAIT. Non-marker bits are then ignored and second_o stays 0 until a marker.
- Assert rst_i at second 30 -> all outputs 0 immediately. After release, non-marker bits leave second_o at 0.

Source files
------------

// File: rtl/msf_frame_ctrl.sv
// MSF frame sequencer: counts seconds from the minute marker, captures A/B bits and
// latches BCD date/time on a checked frame. Optional parity checking: MSF_PARITY_CHECK_EN.
module msf_frame_ctrl #(
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       bits_valid_i,
  input  logic       bits_is_second_00_i,
  input  logic [1:0] bits_data_i,
  output logic [5:0] second_o,
  output logic [7:0] year_o,
  output logic [4:0] month_o,
  output logic [5:0] day_o,
  output logic [2:0] dow_o,
  output logic [5:0] hour_o,
  output logic [6:0] minute_o,
  output logic       time_valid_o,
  output logic       frame_done_o,
  output logic       frame_error_o
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LIMIT = TW'(TIMEOUT_CYCLES);

  // Handshake: bits_valid_i is a single-cycle strobe with no back-pressure; data and
  // marker qualifier are sampled only in that cycle.
  typedef enum logic {SYNC_WAIT, COLLECT} state_t;

  state_t        r_state, w_state_nxt;
  logic [5:0]    r_second, w_second_nxt;
  logic [42:0]   r_a, w_a_nxt;
  logic [TW-1:0] r_to, w_to_nxt;
  logic [7:0]    r_year, w_year_nxt;
  logic [4:0]    r_month, w_month_nxt;
  logic [5:0]    r_day, w_day_nxt;
  logic [2:0]    r_dow, w_dow_nxt;
  logic [5:0]    r_hour, w_hour_nxt;
  logic [6:0]    r_minute, w_minute_nxt;
  logic          r_tv, w_tv_nxt;
  logic          r_done, w_done_nxt;
  logic          r_err, w_err_nxt;

  logic [5:0]    w_s_new;
  logic [TW-1:0] w_to_inc;
  logic          w_timeout;
  logic          w_marker_ok;
  logic          w_frame_ok;

  assign w_s_new     = r_second + 6'd1;
  assign w_to_inc    = r_to + {{(TW-1){1'b0}}, 1'b1};
  assign w_timeout   = (r_state == COLLECT) && !bits_valid_i && (w_to_inc == TO_LIMIT);
  // r_a[0] holds A59 and r_a[42] holds A17 once a full frame has been shifted in.
  assign w_marker_ok = (r_a[7:0] == 8'b0111_1110);

`ifdef MSF_PARITY_CHECK_EN
  logic [3:0] r_b, w_b_nxt;
  logic       w_par_ok;
  // Each group plus its B bit must carry an odd number of ones.
  assign w_par_ok   = (^{r_a[42:35], r_b[0]}) & (^{r_a[34:24], r_b[1]}) &
                      (^{r_a[23:21], r_b[2]}) & (^{r_a[20:8], r_b[3]});
  assign w_frame_ok = w_marker_ok & w_par_ok;
`else
  logic w_unused_b;
  assign w_unused_b = bits_data_i[1];
  assign w_frame_ok = w_marker_ok;
`endif

  always_comb begin
    w_state_nxt  = r_state;
    w_second_nxt = r_second;
    w_a_nxt      = r_a;
    w_to_nxt     = '0;
    w_year_nxt   = r_year;
    w_month_nxt  = r_month;
    w_day_nxt    = r_day;
    w_dow_nxt    = r_dow;
    w_hour_nxt   = r_hour;
    w_minute_nxt = r_minute;
    w_tv_nxt     = r_tv;
    w_done_nxt   = 1'b0;
    w_err_nxt    = 1'b0;
`ifdef MSF_PARITY_CHECK_EN
    w_b_nxt      = r_b;
`endif
    case (r_state)
      SYNC_WAIT: begin
        if (bits_valid_i && bits_is_second_00_i) begin
          w_second_nxt = 6'd0;
          w_a_nxt      = '0;
`ifdef MSF_PARITY_CHECK_EN
          w_b_nxt      = '0;
`endif
          w_state_nxt  = COLLECT;
        end
      end
      COLLECT: begin
        if (!bits_valid_i) w_to_nxt = w_to_inc;
        if (w_timeout) begin
          w_err_nxt    = 1'b1;
          w_tv_nxt     = 1'b0;
          w_second_nxt = 6'd0;
          w_to_nxt     = '0;
          w_state_nxt  = SYNC_WAIT;
        end else if (bits_valid_i && bits_is_second_00_i) begin
          w_second_nxt = 6'd0;
          w_a_nxt      = '0;
`ifdef MSF_PARITY_CHECK_EN
          w_b_nxt      = '0;
`endif
          if (r_second == 6'd59 && w_frame_ok) begin
            w_year_nxt   = r_a[42:35];
            w_month_nxt  = r_a[34:30];
            w_day_nxt    = r_a[29:24];
            w_dow_nxt    = r_a[23:21];
            w_hour_nxt   = r_a[20:15];
            w_minute_nxt = r_a[14:8];
            w_tv_nxt     = 1'b1;
            w_done_nxt   = 1'b1;
          end else begin
            w_tv_nxt  = 1'b0;
            w_err_nxt = 1'b1;
          end
        end else if (bits_valid_i) begin
          if (r_second != 6'd59) begin
            w_second_nxt = w_s_new;
            if (w_s_new >= 6'd17) w_a_nxt = {r_a[41:0], bits_data_i[0]};
`ifdef MSF_PARITY_CHECK_EN
            case (w_s_new)
              6'd54:   w_b_nxt[0] = bits_data_i[1];
              6'd55:   w_b_nxt[1] = bits_data_i[1];
              6'd56:   w_b_nxt[2] = bits_data_i[1];
              6'd57:   w_b_nxt[3] = bits_data_i[1];
              default: ;
            endcase
`endif
          end else begin
            // A 61st second cannot belong to a standard frame; drop sync.
            w_err_nxt    = 1'b1;
            w_tv_nxt     = 1'b0;
            w_second_nxt = 6'd0;
            w_state_nxt  = SYNC_WAIT;
          end
        end
      end
      default: w_state_nxt = SYNC_WAIT;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= SYNC_WAIT;
      r_second <= '0;
      r_a      <= '0;
      r_to     <= '0;
      r_year   <= '0;
      r_month  <= '0;
      r_day    <= '0;
      r_dow    <= '0;
      r_hour   <= '0;
      r_minute <= '0;
      r_tv     <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
`ifdef MSF_PARITY_CHECK_EN
      r_b      <= '0;
`endif
    end else begin
      r_state  <= w_state_nxt;
      r_second <= w_second_nxt;
      r_a      <= w_a_nxt;
      r_to     <= w_to_nxt;
      r_year   <= w_year_nxt;
      r_month  <= w_month_nxt;
      r_day    <= w_day_nxt;
      r_dow    <= w_dow_nxt;
      r_hour   <= w_hour_nxt;
      r_minute <= w_minute_nxt;
      r_tv     <= w_tv_nxt;
      r_done   <= w_done_nxt;
      r_err    <= w_err_nxt;
`ifdef MSF_PARITY_CHECK_EN
      r_b      <= w_b_nxt;
`endif
    end
  end

  assign second_o      = r_second;
  assign year_o        = r_year;
  assign month_o       = r_month;
  assign day_o         = r_day;
  assign dow_o         = r_dow;
  assign hour_o        = r_hour;
  assign minute_o      = r_minute;
  assign time_valid_o  = r_tv;
  assign frame_done_o  = r_done;
  assign frame_error_o = r_err;

endmodule

// File: tb/tb_msf_frame_ctrl.sv
// Bench for msf_frame_ctrl: directed scenarios plus random frames, checked every
// cycle against a per-second array model of the frame rules.
module tb_msf_frame_ctrl;
  localparam int T = 300;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       bits_valid = 1'b0;
  logic       bits_m = 1'b0;
  logic [1:0] bits_data = 2'b00;
  logic [5:0] second_o;
  logic [7:0] year_o;
  logic [4:0] month_o;
  logic [5:0] day_o;
  logic [2:0] dow_o;
  logic [5:0] hour_o;
  logic [6:0] minute_o;
  logic       time_valid_o, frame_done_o, frame_error_o;

  int checks = 0;
  int failures = 0;

  msf_frame_ctrl #(.TIMEOUT_CYCLES(T)) dut (
    .clk_i(clk), .rst_i(rst), .bits_valid_i(bits_valid),
    .bits_is_second_00_i(bits_m), .bits_data_i(bits_data),
    .second_o(second_o), .year_o(year_o), .month_o(month_o), .day_o(day_o),
    .dow_o(dow_o), .hour_o(hour_o), .minute_o(minute_o),
    .time_valid_o(time_valid_o), .frame_done_o(frame_done_o),
    .frame_error_o(frame_error_o)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model: one array slot per second ----------------
  bit m_sync = 0;
  int m_sec = 0, m_idle = 0;
  bit ma[60];
  bit mb[60];
  int e_year = 0, e_month = 0, e_day = 0, e_dow = 0, e_hour = 0, e_min = 0;
  bit e_tv = 0, e_done = 0, e_err = 0;

  function automatic int fld(input int lo, input int hi);
    int v = 0;
    for (int i = lo; i <= hi; i++) v = v * 2 + int'(ma[i]);
    return v;
  endfunction

  function automatic bit odd_group(input int lo, input int hi, input int bi);
    int ones = int'(mb[bi]);
    for (int i = lo; i <= hi; i++) ones += int'(ma[i]);
    return (ones % 2) == 1;
  endfunction

  function automatic bit frame_good();
    bit ok = (fld(52, 59) == 8'h7E);
`ifdef MSF_PARITY_CHECK_EN
    ok = ok && odd_group(17, 24, 54) && odd_group(25, 35, 55) &&
         odd_group(36, 38, 56) && odd_group(39, 51, 57);
`endif
    return ok;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 60; i++) begin ma[i] = 0; mb[i] = 0; end
  endtask

  task automatic model_reset();
    m_sync = 0; m_sec = 0; m_idle = 0; model_clear();
    e_year = 0; e_month = 0; e_day = 0; e_dow = 0; e_hour = 0; e_min = 0;
    e_tv = 0; e_done = 0; e_err = 0;
  endtask

  task automatic model_fail();
    e_err = 1; e_tv = 0;
  endtask

  task automatic model_step(input bit v, input bit mk, input logic [1:0] d);
    e_done = 0; e_err = 0;
    if (!m_sync) begin
      if (v && mk) begin m_sync = 1; m_sec = 0; m_idle = 0; model_clear(); end
    end else if (!v) begin
      m_idle++;
      if (m_idle == T) begin model_fail(); m_sync = 0; m_sec = 0; m_idle = 0; end
    end else begin
      m_idle = 0;
      if (mk) begin
        if (m_sec == 59 && frame_good()) begin
          e_year = fld(17, 24); e_month = fld(25, 29); e_day = fld(30, 35);
          e_dow = fld(36, 38); e_hour = fld(39, 44); e_min = fld(45, 51);
          e_tv = 1; e_done = 1;
        end else model_fail();
        m_sec = 0; model_clear();
      end else if (m_sec < 59) begin
        m_sec++; ma[m_sec] = d[0]; mb[m_sec] = d[1];
      end else begin
        model_fail(); m_sync = 0; m_sec = 0;
      end
    end
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) model_reset();
    else model_step(bits_valid, bits_m, bits_data);
  end

  // ---------------- compare process ----------------
  initial forever begin
    @(negedge clk);
    chk("second", second_o, m_sec);
    chk("year", year_o, e_year);
    chk("month", month_o, e_month);
    chk("day", day_o, e_day);
    chk("dow", dow_o, e_dow);
    chk("hour", hour_o, e_hour);
    chk("minute", minute_o, e_min);
    chk("time_valid", time_valid_o, e_tv);
    chk("frame_done", frame_done_o, e_done);
    chk("frame_error", frame_error_o, e_err);
    chk("done_err_excl", frame_done_o & frame_error_o, 0);
  end

  // ---------------- driver ----------------
  bit fa[60];
  bit fb[60];

  task automatic send_sec(input bit mk, input logic [1:0] d);
    @(negedge clk);
    bits_valid = 1'b1; bits_m = mk; bits_data = d;
    @(negedge clk);
    bits_valid = 1'b0; bits_m = 1'b0; bits_data = 2'b00;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic put_field(input int lo, input int hi, input int val);
    int v = val;
    for (int i = hi; i >= lo; i--) begin fa[i] = v[0]; v = v >> 1; end
  endtask

  task automatic set_frame(input logic [7:0] yr, input logic [4:0] mo, input logic [5:0] dy,
                           input logic [2:0] dw, input logic [5:0] hr, input logic [6:0] mi);
    for (int i = 0; i < 60; i++) begin fa[i] = 0; fb[i] = 0; end
    put_field(17, 24, int'(yr)); put_field(25, 29, int'(mo)); put_field(30, 35, int'(dy));
    put_field(36, 38, int'(dw)); put_field(39, 44, int'(hr)); put_field(45, 51, int'(mi));
    put_field(52, 59, 8'h7E);
    fb[54] = ~(^yr); fb[55] = ~(^{mo, dy}); fb[56] = ~(^dw); fb[57] = ~(^{hr, mi});
  endtask

  task automatic send_frame(input int nsec, input int max_gap);
    for (int s = 1; s <= nsec; s++) begin
      send_sec(1'b0, {fb[s % 60], fa[s % 60]});
      idle($urandom_range(0, max_gap));
    end
    send_sec(1'b1, 2'b00);
  endtask

  task automatic chk_good_literal(input string tag);
    chk({tag, "_year"}, year_o, 8'h23);
    chk({tag, "_month"}, month_o, 5'h07);
    chk({tag, "_day"}, day_o, 6'h14);
    chk({tag, "_dow"}, dow_o, 3'd5);
    chk({tag, "_hour"}, hour_o, 6'h12);
    chk({tag, "_minute"}, minute_o, 7'h34);
    chk({tag, "_tv"}, time_valid_o, 1'b1);
    chk({tag, "_done"}, frame_done_o, 1'b1);
  endtask

  initial begin
    int n;
    bit seen;
    idle(3);
    chk("rst_second", second_o, 0);
    chk("rst_tv", time_valid_o, 0);
    chk("rst_year", year_o, 0);
    @(negedge clk); #2 rst = 1'b0;

    // Good frame 23-07-14 dow 5 12:34; B54..57 come out as 0,0,1,0.
    set_frame(8'h23, 5'h07, 6'h14, 3'd5, 6'h12, 7'h34);
    chk("lit_b56", {fb[54], fb[55], fb[56], fb[57]}, 4'b0010);
    send_sec(1'b1, 2'b00);
    send_frame(59, 1);
    chk_good_literal("good1");
    @(negedge clk);
    chk("good1_done_pulse", frame_done_o, 1'b0);

    // Marker bit A53 cleared.
    fa[53] = 0;
    send_frame(59, 1);
    chk("badmk_err", frame_error_o, 1'b1);
    chk("badmk_tv", time_valid_o, 1'b0);
    chk("badmk_year_kept", year_o, 8'h23);
    fa[53] = 1;

    // B56 flipped.
    fb[56] = 0;
    send_frame(59, 1);
`ifdef MSF_PARITY_CHECK_EN
    chk("par_err", frame_error_o, 1'b1);
`else
    chk("par_ignored_done", frame_done_o, 1'b1);
`endif
    fb[56] = 1;

    // Short frame then good frame.
    send_frame(58, 1);
    chk("short_err", frame_error_o, 1'b1);
    chk("short_second", second_o, 0);
    send_frame(59, 1);
    chk_good_literal("good2");

    // Timeout after a good frame.
    n = 0; seen = 0;
    while (!seen && n < T + 20) begin
      @(negedge clk); n++;
      if (frame_error_o) seen = 1;
    end
    chk("timeout_at", n, T);
    chk("timeout_tv", time_valid_o, 1'b0);
    for (int i = 0; i < 4; i++) begin
      send_sec(1'b0, 2'(i));
      chk("sync_wait_second", second_o, 0);
    end

    // Reset at second 30.
    send_sec(1'b1, 2'b00);
    for (int i = 0; i < 30; i++) send_sec(1'b0, 2'($urandom_range(0, 3)));
    chk("pre_rst_second", second_o, 30);
    @(negedge clk); #2 rst = 1'b1;
    #1;
    chk("mid_rst_second", second_o, 0);
    chk("mid_rst_year", year_o, 0);
    chk("mid_rst_tv", time_valid_o, 0);
    @(negedge clk); #2 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      send_sec(1'b0, 2'b01);
      chk("post_rst_second", second_o, 0);
    end

    // Random frames of mixed kinds.
    send_sec(1'b1, 2'b00);
    for (int f = 0; f < 40; f++) begin
      int kind = $urandom_range(0, 9);
      set_frame(8'($urandom), 5'($urandom), 6'($urandom), 3'($urandom),
                6'($urandom), 7'($urandom));
      for (int i = 0; i < 17; i++) fa[i] = 1'($urandom);
      case (kind)
        0: send_frame($urandom_range(45, 58), 2);
        1: send_frame(60, 1);
        2: begin fa[$urandom_range(52, 59)] ^= 1; send_frame(59, 2); end
        3: begin fb[$urandom_range(54, 57)] ^= 1; send_frame(59, 2); end
        4: begin
          for (int s = 1; s <= 20; s++) send_sec(1'b0, {fb[s], fa[s]});
          idle(T + 5);
          send_frame(59, 1);
        end
        default: send_frame(59, 3);
      endcase
    end
    idle(5);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
